// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver, one byte per valid strobe. Defining
//            UART_RX_PARITY_EN adds an even-parity bit (11-bit frame).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_start     = 3'd1;
    localparam logic [2:0] c_data      = 3'd2;
    localparam logic [2:0] c_stop      = 3'd3;
    localparam logic [2:0] c_wait_high = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_parity    = 3'd5;
`endif

    localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_m1  = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_out;
    logic             r_valid;
    logic             r_frame_err;
    logic             w_fall;
    logic             w_mid;
    logic             w_end;
    logic             w_pend;
    logic             w_busy;
    logic             w_valid_set;
    logic             w_ferr_set;
    logic             w_perr_set;

    assign w_fall = r_prev & ~r_sync2;
    assign w_mid  = (r_cnt == c_half_m1);
    assign w_end  = (r_cnt == c_bit_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:      if (w_fall) w_next = c_start;
            c_start:     if (w_mid) w_next = r_sync2 ? c_idle : c_data;
            c_data: begin
                if (w_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = c_parity;
`else
                    w_next = c_stop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_parity:    if (w_end) w_next = c_stop;
`endif
            c_stop:      if (w_end) w_next = r_sync2 ? c_idle : c_wait_high;
            c_wait_high: if (r_sync2) w_next = c_idle;
            default:     w_next = c_idle;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != c_idle);
        w_valid_set = 1'b0;
        w_ferr_set  = 1'b0;
        w_perr_set  = 1'b0;
        if ((r_state == c_stop) && w_end) begin
            w_valid_set = r_sync2 & ~w_pend;
            w_perr_set  = r_sync2 & w_pend;
            w_ferr_set  = ~r_sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // The counter restarts on every state change and at each data-bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if ((w_next != r_state) || ((r_state == c_data) && w_end)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == c_start) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == c_data) && w_end) begin
                r_shift[r_bit_idx] <= r_sync2;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_valid_set;
            r_frame_err <= w_ferr_set;
            if (w_valid_set) begin
                r_out <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_pend;
    logic r_parity_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_pend   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_set;
            if (r_state == c_start) begin
                r_par_pend <= 1'b0;
            end else if ((r_state == c_parity) && w_end) begin
                r_par_pend <= (r_sync2 != ^r_shift);
            end
        end
    end

    assign w_pend     = r_par_pend;
    assign parity_err = r_parity_err;
`else
    assign w_pend     = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign out       = r_out;
    assign valid     = r_valid;
    assign busy      = w_busy;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ============================================================================
// Module   : tb_uart_rx_byte
// Brief    : Directed and randomized frame stimulus against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_byte;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_BITS = PAR ? 11 : 10;
    localparam int LAT_NOM    = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .out        (out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_excl = 0, n_busy = 0;
    int         last_vcyc = 0, prev_vcyc = 0;
    int         t_start = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] reg_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 8-bit enabled register fed by out/valid.
    always @(posedge clk or posedge reset) begin
        if (reset) reg_q <= 8'h00;
        else if (valid) reg_q <= out;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                n_valid   <= n_valid + 1;
                got_q.push_back(out);
                prev_vcyc <= last_vcyc;
                last_vcyc <= cyc;
            end
            if (frame_err)  n_ferr <= n_ferr + 1;
            if (parity_err) n_perr <= n_perr + 1;
            if (busy)       n_busy <= n_busy + 1;
            if ((int'(valid) + int'(frame_err) + int'(parity_err) > 1) ||
                ((valid | frame_err | parity_err) && prev_pulse))
                n_excl <= n_excl + 1;
            prev_pulse <= valid | frame_err | parity_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Caller is always sitting on a falling clock edge when this starts.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR) begin
            rx = (^d) ^ pbad;
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_good(input string tag, input logic [7:0] d, input int nv0);
        check({tag, "_valid_cnt"}, n_valid, nv0 + 1);
        check({tag, "_q_size"}, got_q.size(), 1);
        if (got_q.size() > 0) check({tag, "_data"}, got_q.pop_front(), {24'h0, d});
        check({tag, "_out"}, out, {24'h0, d});
    endtask

    int         nv0, nf0, np0, nb0, lat;
    logic [7:0] exp_out, d;
    logic       stopbad, pbad;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        reset = 1'b0;

        idle(400);
        check("idle_out", out, 0);
        check("idle_valid_cnt", n_valid, 0);
        check("idle_busy_cnt", n_busy, 0);
        check("idle_ferr_cnt", n_ferr, 0);

        nv0 = n_valid; nb0 = n_busy;
        send_frame(8'hA5, 1'b1, 1'b0);
        expect_good("a5", 8'hA5, nv0);
        lat = last_vcyc - t_start;
        check("a5_latency_window", (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1);
        check("a5_busy_seen", n_busy > nb0, 1);
        check("a5_busy_after", busy, 0);
        check("a5_reg", reg_q, 8'hA5);
        idle(20);

        nv0 = n_valid;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("b2b_valid_cnt", n_valid, nv0 + 2);
        check("b2b_q_size", got_q.size(), 2);
        if (got_q.size() > 0) check("b2b_first", got_q.pop_front(), 8'h3C);
        if (got_q.size() > 0) check("b2b_second", got_q.pop_front(), 8'hC3);
        check("b2b_spacing", last_vcyc - prev_vcyc, FRAME_BITS * CPB);
        check("b2b_reg", reg_q, 8'hC3);
        idle(20);

        nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_valid", n_valid, nv0);
        check("glitch_ferr", n_ferr, nf0);
        check("glitch_perr", n_perr, np0);
        check("glitch_busy", busy, 0);

        nv0 = n_valid; nf0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("ferr_cnt", n_ferr, nf0 + 1);
        check("ferr_valid", n_valid, nv0);
        check("ferr_out_held", out, 8'hC3);
        check("ferr_busy_low_line", busy, 1);
        idle(5);
        check("ferr_busy_released", busy, 0);
        idle(20);

        // Abort a frame midway through data bit 4 of 8'hFF.
        nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out", out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_ferr", frame_err, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(6 * CPB);
        check("midrst_no_pulse", n_valid + n_ferr + n_perr, nv0 + nf0 + np0);
        nv0 = n_valid;
        send_frame(8'h81, 1'b1, 1'b0);
        expect_good("after_rst", 8'h81, nv0);
        check("after_rst_reg", reg_q, 8'h81);
        exp_out = 8'h81;
        idle(10);

`ifdef UART_RX_PARITY_EN
        nv0 = n_valid; np0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        expect_good("par_ok", 8'h07, nv0);
        check("par_ok_perr", n_perr, np0);
        idle(10);
        nv0 = n_valid;
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_bad_perr", n_perr, np0 + 1);
        check("par_bad_valid", n_valid, nv0);
        check("par_bad_out", out, 8'h07);
        exp_out = 8'h07;
        idle(10);
`endif

        for (int k = 0; k < 20; k++) begin
            d       = 8'($urandom);
            stopbad = ($urandom_range(0, 5) == 0);
            pbad    = PAR ? ($urandom_range(0, 4) == 0) : 1'b0;
            nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
            send_frame(d, ~stopbad, pbad);
            if (stopbad) begin
                check("rnd_ferr", n_ferr, nf0 + 1);
                check("rnd_ferr_perr", n_perr, np0);
                check("rnd_ferr_valid", n_valid, nv0);
            end else if (pbad) begin
                check("rnd_perr", n_perr, np0 + 1);
                check("rnd_perr_valid", n_valid, nv0);
            end else begin
                expect_good("rnd", d, nv0);
                check("rnd_ferr_none", n_ferr, nf0);
                exp_out = d;
            end
            check("rnd_out", out, {24'h0, exp_out});
            idle(stopbad ? $urandom_range(5, 15) : $urandom_range(0, 12));
        end
        idle(5);
        check("rnd_busy_end", busy, 0);

        check("pulse_exclusive", n_excl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-to-parallel receive stage sitting directly upstream of the team's 8-bit enabled register.
- Recovers 8N1 asynchronous serial frames from a single input line.
- Presents each received byte on `out` with a one-cycle `valid` strobe; `valid` wires straight to the register's `enable`, `out` to its `in`.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Must be an even value, 4 or greater.
- CNT_W, default 8: bit-counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- out  output  8  last good received byte.
- valid  output  1  one-cycle pulse when `out` is updated.
- busy  output  1  high while a frame is being received.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- parity_err  output  1  one-cycle pulse on parity mismatch. Tied 0 when PARITY_EN is not defined.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; out=8'h00; valid=0; busy=0; frame_err=0; parity_err=0; sync flops=1; counters=0.
- rx passes through a 2-flop synchronizer giving rx_s. A previous-sample flop gives falling-edge detect (prev=1, rx_s=0).
- All bit timing uses the cycle counter cnt. cnt is cleared at every state change.
- IDLE: busy=0. On rx_s falling edge -> START, cnt=0.
- START: busy=1. At cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s:
  - rx_s==0 -> DATA, bit_idx=0.
  - rx_s==1 -> IDLE. This is a glitch: no error pulse.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx], LSB first, then increment bit_idx.
  - After bit 7 -> STOP, or -> PARITY when PARITY_EN is defined.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1 and no pending parity error: out<=shift and valid=1 in the next cycle, for exactly 1 cycle -> IDLE.
  - rx_s==0: frame_err=1 for 1 cycle; out is held -> WAIT_HIGH.
- WAIT_HIGH: busy=1. Remain until rx_s==1 -> IDLE. This prevents a break condition from retriggering the receiver.
- Latency: valid rises 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) after the rx falling edge, ±1 cycle.
- valid, frame_err and parity_err are mutually exclusive and never assert in back-to-back cycles for one frame.
- A new start edge seen in the cycle the receiver enters IDLE is accepted. Back-to-back frames with no idle gap are received correctly.
- Reset asserted mid-frame: the frame is aborted immediately, outputs return to reset values, and no pulse is emitted.
- rx activity during DATA/STOP other than at sample points is ignored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state after DATA samples one even-parity bit at cnt==CLKS_PER_BIT-1.
  - A mismatch latches a pending flag, the frame continues to STOP, and then parity_err pulses 1 cycle instead of valid. out is not updated.
  - A bad stop bit takes precedence: frame_err pulses, parity_err does not.
  - Frame length is 11 bits.
- Undefined: no PARITY state, parity_err is constant 0, and the frame is 10 bits.

Test Plan (CLKS_PER_BIT=16):
- Reset then idle: reset high 3 cycles, rx=1 for 400 cycles -> out=8'h00, valid/busy/frame_err stay 0.
- Single frame 8'hA5 (bits 1,0,1,0,0,1,0,1), correct stop -> valid pulses exactly once, out=8'hA5, busy falls after the stop bit. Feeding out/valid into the 8-bit register yields register out=8'hA5.
- Back-to-back frames 8'h3C then 8'hC3 with no idle gap -> two valid pulses ~160 cycles apart, out=8'h3C then 8'hC3.
- Glitch: rx low for 4 cycles then high -> returns to IDLE, no valid, no error. Framing error: frame 8'h55 with stop bit=0, rx held low 50 cycles -> frame_err pulses once, out stays at its prior value, busy stays high until rx=1.
- Reset mid-frame: assert reset during DATA bit 4 of 8'hFF -> all outputs 0 immediately. The next clean frame 8'h81 is received with out=8'h81.
- UART_RX_PARITY_EN defined: 8'h07 with parity bit 1 -> valid, out=8'h07. Same byte with parity bit 0 -> parity_err pulse, out unchanged.
